// File: rtl/bp_ctrl.sv
// bp_ctrl: branch resolution and BTB update controller at the EX stage.
//
// Compares each resolved branch against the prediction carried down on
// bp_to_ex_bus, drives the fetch redirect on br_bus, and queues BTB
// WRITE/KILL requests in a small in-order FIFO. The FIFO drains to the BTB
// write port over a valid/ready handshake. An inv_all pulse empties the FIFO
// and sequences a CLR sweep over every BTB entry.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   stall[5:0]          stall bus; stall[4] set holds EX
//   flush               kills EX resolution this cycle
//   ex_valid/pc/taken/target  resolved EX instruction
//   bp_to_ex_bus[32:0]  {pred_e, pred_target}
//   br_bus[32:0]        {redirect_e, redirect_target}, combinational
//   upd_valid/ready     BTB update handshake
//   upd_op              00 WRITE, 01 KILL, 10 CLR
//   upd_pc/target/idx   update payload
//   inv_all             one-cycle request to invalidate the whole BTB
//   busy                sweep in progress
//   mispredict_cnt      saturating redirect count
//   ovf_cnt             saturating dropped-update count
module bp_ctrl #(
  parameter int DEPTH = 4,
  parameter int WAYS  = 2,
  localparam int IW   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [5:0]    stall,
  input  logic          flush,
  input  logic          ex_valid,
  input  logic [31:0]   ex_pc,
  input  logic          ex_taken,
  input  logic [31:0]   ex_target,
  input  logic [32:0]   bp_to_ex_bus,
  output logic [32:0]   br_bus,
  output logic          upd_valid,
  input  logic          upd_ready,
  output logic [1:0]    upd_op,
  output logic [31:0]   upd_pc,
  output logic [31:0]   upd_target,
  output logic [IW-1:0] upd_idx,
  input  logic          inv_all,
  output logic          busy,
  output logic [31:0]   mispredict_cnt,
  output logic [15:0]   ovf_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0]    OP_WRITE = 2'b00;
  localparam logic [1:0]    OP_KILL  = 2'b01;
  localparam logic [1:0]    OP_CLR   = 2'b10;
  localparam logic [IW-1:0] LAST_IDX = IW'(WAYS - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {RUN = 1'b0, SWEEP = 1'b1} state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t        state, next_state;
  logic [IW-1:0] sweep_idx;

  logic [1:0]    mem_op  [DEPTH];
  logic [31:0]   mem_pc  [DEPTH];
  logic [31:0]   mem_tgt [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic          pred_e;
  logic [31:0]   pred_target;
  logic          fire;
  logic          redir_taken, redir_nt, redirect;
  logic [31:0]   redir_target;
  logic          full, handshake, pop, enq_ok, push, drop;
  logic          unused_stall;

  // Only the EX stop bit of the stall bus matters here.
  assign unused_stall = ^{stall[5], stall[3:0]};

  assign pred_e      = bp_to_ex_bus[32];
  assign pred_target = bp_to_ex_bus[31:0];
  assign fire        = ex_valid & ~stall[4] & ~flush;

  // Taken but unpredicted or predicted to the wrong place: install the real
  // target. Predicted but not taken: fall through past the delay slot and
  // remove the stale entry.
  assign redir_taken  = ex_taken & (~pred_e | (pred_target != ex_target));
  assign redir_nt     = pred_e & ~ex_taken;
  assign redirect     = fire & (redir_taken | redir_nt);
  assign redir_target = redir_taken ? ex_target : ex_pc + 32'd8;

  assign br_bus = (rst && redirect) ? {1'b1, redir_target} : 33'd0;

  assign full      = (count == FULL_CNT);
  assign handshake = upd_valid & upd_ready;
  assign pop       = (state == RUN) & handshake;
  // Updates are only accepted while draining normally; inv_all and sweeps
  // discard them without counting them as overflow.
  assign enq_ok    = redirect & (state == RUN) & ~inv_all;
  assign push      = enq_ok & (~full | pop);
  assign drop      = enq_ok & full & ~pop;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= RUN;
    else      state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      RUN:   if (inv_all) next_state = SWEEP;
      SWEEP: begin
        if (inv_all)                                next_state = SWEEP;
        else if (upd_ready && sweep_idx == LAST_IDX) next_state = RUN;
      end
      default: next_state = RUN;
    endcase
  end

  // Output logic: payloads read as zero whenever nothing is offered.
  always_comb begin
    upd_valid  = 1'b0;
    upd_op     = OP_WRITE;
    upd_pc     = 32'd0;
    upd_target = 32'd0;
    upd_idx    = '0;
    busy       = 1'b0;
    case (state)
      RUN: begin
        if (count != '0) begin
          upd_valid  = 1'b1;
          upd_op     = mem_op[rd_ptr];
          upd_pc     = mem_pc[rd_ptr];
          upd_target = mem_tgt[rd_ptr];
        end
      end
      SWEEP: begin
        upd_valid = 1'b1;
        upd_op    = OP_CLR;
        upd_idx   = sweep_idx;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Sweep counter; inv_all restarts from entry 0 even mid-sweep.
  always_ff @(posedge clk) begin
    if (!rst || inv_all) begin
      sweep_idx <= '0;
    end else if (state == SWEEP && upd_ready) begin
      sweep_idx <= (sweep_idx == LAST_IDX) ? '0 : sweep_idx + 1'b1;
    end
  end

  // FIFO control
  always_ff @(posedge clk) begin
    if (!rst || inv_all) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are only observed through count, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_op[wr_ptr]  <= redir_taken ? OP_WRITE : OP_KILL;
      mem_pc[wr_ptr]  <= ex_pc;
      mem_tgt[wr_ptr] <= redir_taken ? ex_target : 32'd0;
    end
  end

  // Statistics
  always_ff @(posedge clk) begin
    if (!rst) begin
      mispredict_cnt <= 32'd0;
      ovf_cnt        <= 16'd0;
    end else begin
      if (redirect) mispredict_cnt <= sat_inc32(mispredict_cnt);
      if (drop)     ovf_cnt        <= sat_inc16(ovf_cnt);
    end
  end

endmodule

// File: tb/tb_bp_ctrl.sv
// Directed self-checking bench for bp_ctrl (DEPTH=4, WAYS=2).
module tb_bp_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic [32:0] bp_to_ex_bus;
  logic [32:0] br_bus;
  logic        upd_valid;
  logic        upd_ready;
  logic [1:0]  upd_op;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic [0:0]  upd_idx;
  logic        inv_all;
  logic        busy;
  logic [31:0] mispredict_cnt;
  logic [15:0] ovf_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  bp_ctrl #(.DEPTH(4), .WAYS(2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken),
    .ex_target(ex_target), .bp_to_ex_bus(bp_to_ex_bus), .br_bus(br_bus),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_op(upd_op),
    .upd_pc(upd_pc), .upd_target(upd_target), .upd_idx(upd_idx),
    .inv_all(inv_all), .busy(busy), .mispredict_cnt(mispredict_cnt),
    .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic pe, input logic [31:0] pt, input logic [31:0] pc,
                        input logic tk, input logic [31:0] tg);
    ex_valid     = 1'b1;
    bp_to_ex_bus = {pe, pt};
    ex_pc        = pc;
    ex_taken     = tk;
    ex_target    = tg;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_ex(1'b0, 32'h0, 32'h100, 1'b1, 32'h200);
    upd_ready = 1'b1;
    #1;
    n_checks++; if (br_bus !== 33'd0) begin n_fail++; $display("FAIL reset_br_bus: got %h expected 0", br_bus); end
    tick();
    n_checks++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_upd_valid: got %b expected 0", upd_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (mispredict_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_mcnt: got %h expected 0", mispredict_cnt); end
    n_checks++; if (ovf_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_ovf: got %h expected 0", ovf_cnt); end
    n_checks++; if ({upd_op, upd_pc, upd_target, upd_idx} !== 67'd0) begin n_fail++; $display("FAIL reset_payload: got %h/%h/%h/%h expected 0", upd_op, upd_pc, upd_target, upd_idx); end
    rst = 1'b1; ex_valid = 1'b0; upd_ready = 1'b0;
    tick();
  endtask

  task automatic test_write_mispredict();
    set_ex(1'b0, 32'h0, 32'h100, 1'b1, 32'h200);
    #1;
    n_checks++; if (br_bus !== {1'b1, 32'h200}) begin n_fail++; $display("FAIL write_br_bus: got %h expected %h", br_bus, {1'b1, 32'h200}); end
    tick();
    ex_valid = 1'b0;
    n_checks++; if (upd_valid !== 1'b1) begin n_fail++; $display("FAIL write_upd_valid: got %b expected 1", upd_valid); end
    n_checks++; if ({upd_op, upd_pc, upd_target} !== {2'b00, 32'h100, 32'h200}) begin n_fail++; $display("FAIL write_payload: got %h/%h/%h expected 0/100/200", upd_op, upd_pc, upd_target); end
    n_checks++; if (mispredict_cnt !== 32'd1) begin n_fail++; $display("FAIL write_mcnt: got %0d expected 1", mispredict_cnt); end
    upd_ready = 1'b1;
    tick();
    n_checks++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL write_drained: got %b expected 0", upd_valid); end
    upd_ready = 1'b0;
  endtask

  task automatic test_kill_wrap();
    set_ex(1'b1, 32'h300, 32'hFFFF_FFFC, 1'b0, 32'h0);
    #1;
    n_checks++; if (br_bus !== {1'b1, 32'h4}) begin n_fail++; $display("FAIL kill_br_bus: got %h expected %h", br_bus, {1'b1, 32'h4}); end
    tick();
    ex_valid = 1'b0;
    n_checks++; if ({upd_valid, upd_op, upd_pc} !== {1'b1, 2'b01, 32'hFFFF_FFFC}) begin n_fail++; $display("FAIL kill_entry: got %b/%h/%h expected 1/1/fffffffc", upd_valid, upd_op, upd_pc); end
    n_checks++; if (mispredict_cnt !== 32'd2) begin n_fail++; $display("FAIL kill_mcnt: got %0d expected 2", mispredict_cnt); end
    upd_ready = 1'b1;
    tick();
    upd_ready = 1'b0;
  endtask

  task automatic test_no_resolve();
    set_ex(1'b1, 32'h200, 32'h180, 1'b1, 32'h200);
    #1;
    n_checks++; if (br_bus !== 33'd0) begin n_fail++; $display("FAIL correct_br_bus: got %h expected 0", br_bus); end
    tick();
    set_ex(1'b0, 32'h0, 32'h180, 1'b1, 32'h200);
    stall = 6'b010000;
    #1;
    n_checks++; if (br_bus !== 33'd0) begin n_fail++; $display("FAIL stall_br_bus: got %h expected 0", br_bus); end
    tick();
    stall = 6'd0; flush = 1'b1;
    #1;
    n_checks++; if (br_bus !== 33'd0) begin n_fail++; $display("FAIL flush_br_bus: got %h expected 0", br_bus); end
    tick();
    flush = 1'b0; ex_valid = 1'b0;
    n_checks++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL no_resolve_upd: got %b expected 0", upd_valid); end
    n_checks++; if (mispredict_cnt !== 32'd2) begin n_fail++; $display("FAIL no_resolve_mcnt: got %0d expected 2", mispredict_cnt); end
  endtask

  task automatic test_overflow();
    upd_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_ex(1'b0, 32'h0, 32'h1000 + 32'(i * 4), 1'b1, 32'h2000 + 32'(i * 4));
      tick();
    end
    ex_valid = 1'b0;
    n_checks++; if (ovf_cnt !== 16'd2) begin n_fail++; $display("FAIL ovf_cnt: got %0d expected 2", ovf_cnt); end
    n_checks++; if (mispredict_cnt !== 32'd8) begin n_fail++; $display("FAIL ovf_mcnt: got %0d expected 8", mispredict_cnt); end
    tick();
    n_checks++; if ({upd_valid, upd_pc, upd_target} !== {1'b1, 32'h1000, 32'h2000}) begin n_fail++; $display("FAIL ovf_hold: got %b/%h/%h expected 1/1000/2000", upd_valid, upd_pc, upd_target); end
    upd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if ({upd_valid, upd_op, upd_pc, upd_target} !== {1'b1, 2'b00, 32'h1000 + 32'(i * 4), 32'h2000 + 32'(i * 4)}) begin n_fail++; $display("FAIL ovf_drain%0d: got %b/%h/%h/%h expected 1/0/%h/%h", i, upd_valid, upd_op, upd_pc, upd_target, 32'h1000 + 32'(i * 4), 32'h2000 + 32'(i * 4)); end
      tick();
    end
    n_checks++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %b expected 0", upd_valid); end
    upd_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) begin
      set_ex(1'b0, 32'h0, 32'h3000 + 32'(i * 4), 1'b1, 32'h5000);
      tick();
    end
    set_ex(1'b0, 32'h0, 32'h3010, 1'b1, 32'h5000);
    upd_ready = 1'b1;
    tick();
    ex_valid = 1'b0; upd_ready = 1'b0;
    n_checks++; if (ovf_cnt !== 16'd2) begin n_fail++; $display("FAIL full_pushpop_ovf: got %0d expected 2", ovf_cnt); end
    upd_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      n_checks++; if ({upd_valid, upd_pc} !== {1'b1, 32'h3000 + 32'(i * 4)}) begin n_fail++; $display("FAIL full_pushpop_drain%0d: got %b/%h expected 1/%h", i, upd_valid, upd_pc, 32'h3000 + 32'(i * 4)); end
      tick();
    end
    n_checks++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL full_pushpop_empty: got %b expected 0", upd_valid); end
    upd_ready = 1'b0;
  endtask

  task automatic test_sweep();
    set_ex(1'b0, 32'h0, 32'h4000, 1'b1, 32'h4100); tick();
    set_ex(1'b0, 32'h0, 32'h4004, 1'b1, 32'h4104); tick();
    ex_valid = 1'b0;
    inv_all = 1'b1;
    tick();
    inv_all = 1'b0;
    n_checks++; if ({busy, upd_valid, upd_op, upd_idx} !== {1'b1, 1'b1, 2'b10, 1'b0}) begin n_fail++; $display("FAIL sweep_start: got %b/%b/%h/%h expected 1/1/2/0", busy, upd_valid, upd_op, upd_idx); end
    set_ex(1'b0, 32'h0, 32'h5000, 1'b1, 32'h6000);
    #1;
    n_checks++; if (br_bus !== {1'b1, 32'h6000}) begin n_fail++; $display("FAIL sweep_br_bus: got %h expected %h", br_bus, {1'b1, 32'h6000}); end
    tick();
    ex_valid = 1'b0;
    n_checks++; if (mispredict_cnt !== 32'd16) begin n_fail++; $display("FAIL sweep_mcnt: got %0d expected 16", mispredict_cnt); end
    n_checks++; if (ovf_cnt !== 16'd2) begin n_fail++; $display("FAIL sweep_ovf: got %0d expected 2", ovf_cnt); end
    n_checks++; if ({busy, upd_idx} !== {1'b1, 1'b0}) begin n_fail++; $display("FAIL sweep_hold: got %b/%h expected 1/0", busy, upd_idx); end
    upd_ready = 1'b1;
    tick();
    n_checks++; if ({busy, upd_valid, upd_op, upd_idx} !== {1'b1, 1'b1, 2'b10, 1'b1}) begin n_fail++; $display("FAIL sweep_idx1: got %b/%b/%h/%h expected 1/1/2/1", busy, upd_valid, upd_op, upd_idx); end
    tick();
    n_checks++; if ({busy, upd_valid} !== 2'b00) begin n_fail++; $display("FAIL sweep_end: got %b/%b expected 0/0", busy, upd_valid); end
    upd_ready = 1'b0;
  endtask

  task automatic test_reset_mid_sweep();
    inv_all = 1'b1;
    tick();
    inv_all = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rsweep_busy: got %b expected 1", busy); end
    rst = 1'b0;
    set_ex(1'b0, 32'h0, 32'h7000, 1'b1, 32'h8000);
    #1;
    n_checks++; if (br_bus !== 33'd0) begin n_fail++; $display("FAIL rsweep_br_bus: got %h expected 0", br_bus); end
    tick();
    n_checks++; if ({busy, upd_valid, upd_op, upd_idx} !== 5'd0) begin n_fail++; $display("FAIL rsweep_outputs: got %b/%b/%h/%h expected 0", busy, upd_valid, upd_op, upd_idx); end
    n_checks++; if ({mispredict_cnt, ovf_cnt} !== 48'd0) begin n_fail++; $display("FAIL rsweep_counters: got %h/%h expected 0", mispredict_cnt, ovf_cnt); end
    rst = 1'b1; ex_valid = 1'b0;
    tick();
    inv_all = 1'b1;
    tick();
    inv_all = 1'b0;
    n_checks++; if ({busy, upd_op, upd_idx} !== {1'b1, 2'b10, 1'b0}) begin n_fail++; $display("FAIL rsweep_restart: got %b/%h/%h expected 1/2/0", busy, upd_op, upd_idx); end
    upd_ready = 1'b1;
    tick();
    n_checks++; if (upd_idx !== 1'b1) begin n_fail++; $display("FAIL rsweep_idx1: got %h expected 1", upd_idx); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rsweep_done: got %b expected 0", busy); end
    upd_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; stall = 6'd0; flush = 1'b0; ex_valid = 1'b0; ex_pc = 32'd0;
    ex_taken = 1'b0; ex_target = 32'd0; bp_to_ex_bus = 33'd0;
    upd_ready = 1'b0; inv_all = 1'b0;
    test_reset();
    test_write_mispredict();
    test_kill_wrap();
    test_no_resolve();
    test_overflow();
    test_full_push_pop();
    test_sweep();
    test_reset_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
